// File: rtl/ssem_exec_unit.sv
// ssem_exec_unit: SSEM register file + add/sub ALU with a valid/ready command sequencer.
// Optional signed-overflow flag output flag_v is enabled by defining SSEM_EXEC_OVF_EN.
module ssem_exec_unit #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_op,
    input  logic [$clog2(NUM_REGS)-1:0] cmd_dst,
    input  logic [$clog2(NUM_REGS)-1:0] cmd_src_a,
    input  logic [$clog2(NUM_REGS)-1:0] cmd_src_b,
    output logic                        done,
    output logic                        bus_drive,
    output logic                        flag_z,
    output logic                        flag_n,
    output logic                        flag_c,
`ifdef SSEM_EXEC_OVF_EN
    output logic                        flag_v,
`endif
    inout  wire  [WIDTH-1:0]            bus
);
    localparam int RAW = $clog2(NUM_REGS);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_WB    = 2'd2;
    localparam logic [1:0] S_DRIVE = 2'd3;
    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_NEG   = 3'd4;
    localparam logic [2:0] OP_CMP   = 3'd5;

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [RAW-1:0]   r_dst, r_src_a, r_src_b;
    logic [WIDTH-1:0] r_regs [NUM_REGS];
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [WIDTH-1:0] w_a, w_b, w_x, w_y;
    logic [WIDTH:0]   w_sum;
    logic             w_sub, w_c, w_wr, w_fl;

    // One adder serves all ops: NEG is 0-a, SUB/CMP add the inverted operand plus one.
    always_comb begin
        w_a   = r_regs[r_src_a];
        w_b   = r_regs[r_src_b];
        w_sub = r_op != OP_ADD;
        w_x   = (r_op == OP_NEG) ? '0 : w_a;
        w_y   = (r_op == OP_NEG) ? w_a : w_b;
        w_sum = {1'b0, w_x} + {1'b0, w_sub ? ~w_y : w_y} + {{WIDTH{1'b0}}, w_sub};
        w_c   = w_sum[WIDTH] ^ w_sub;
        w_wr  = (r_op <= OP_NEG) && (r_op != OP_STORE) && (r_dst != '0);
        w_fl  = (r_op >= OP_ADD) && (r_op <= OP_CMP);
    end

`ifdef SSEM_EXEC_OVF_EN
    logic w_v, r_v;
    assign w_v = (w_x[WIDTH-1] == (w_sub ? ~w_y[WIDTH-1] : w_y[WIDTH-1])) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
`endif

    assign cmd_ready = r_state == S_IDLE;
    assign done      = (r_state == S_WB) || (r_state == S_DRIVE);
    assign bus_drive = r_state == S_DRIVE;
    assign bus       = bus_drive ? w_a : 'z;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_dst   <= '0;
            r_src_a <= '0;
            r_src_b <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_c  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
`ifdef SSEM_EXEC_OVF_EN
            r_v     <= 1'b0;
            flag_v  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    r_op    <= cmd_op;
                    r_dst   <= cmd_dst;
                    r_src_a <= cmd_src_a;
                    r_src_b <= cmd_src_b;
                    r_state <= (cmd_op == OP_STORE) ? S_DRIVE : (cmd_op >= 3'd6) ? S_WB : S_EXEC;
                end
                S_EXEC: begin
                    r_res   <= (r_op == OP_LOAD) ? bus : w_sum[WIDTH-1:0];
                    r_c     <= w_c;
`ifdef SSEM_EXEC_OVF_EN
                    r_v     <= w_v;
`endif
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (w_wr) r_regs[r_dst] <= r_res;
                    if (w_fl) begin
                        flag_z <= r_res == '0;
                        flag_n <= r_res[WIDTH-1];
                        flag_c <= r_c;
`ifdef SSEM_EXEC_OVF_EN
                        flag_v <= r_v;
`endif
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
